// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline latches: occupancy encodings
// and per-stage payload widths.
package pipe_pkg;

  // Occupancy is {h_v, s_v}; 2'b01 is unreachable by construction.
  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_ONE   = 2'b10;
  localparam logic [1:0] OCC_FULL  = 2'b11;

  // Fetch -> decode payload: pc, raw instruction, predicted-taken flag.
  localparam int unsigned FD_PC_W    = 32;
  localparam int unsigned FD_INSTR_W = 32;
  localparam int unsigned FD_PRED_W  = 1;
  localparam int unsigned FD_W       = FD_PC_W + FD_INSTR_W + FD_PRED_W;

endpackage

// File: rtl/regn_en.sv
// WIDTH-bit register with load enable and synchronous clear (clear wins).
module regn_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_latch.sv
// Pipeline stage latch with a head entry plus one skid entry, so in_ready can
// come straight from a flop; also counts back-pressure cycles, saturating.
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             h_v_q, h_v_d;
  logic             s_v_q, s_v_d;
  logic [WIDTH-1:0] h_d_q, s_d_q;
  logic [WIDTH-1:0] h_din;
  logic             h_ld, s_ld;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             acc, fire;

  assign acc  = in_valid & ~s_v_q;
  assign fire = h_v_q & out_ready;

  always_comb begin
    h_v_d = h_v_q;
    s_v_d = s_v_q;
    h_ld  = 1'b0;
    s_ld  = 1'b0;
    h_din = in_data;
    unique case ({h_v_q, s_v_q})
      OCC_EMPTY: begin
        if (acc) begin
          h_v_d = 1'b1;
          h_ld  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (fire && !acc) begin
          h_v_d = 1'b0;
        end else if (fire && acc) begin
          h_ld = 1'b1;
        end else if (acc) begin
          s_v_d = 1'b1;
          s_ld  = 1'b1;
        end
      end
      OCC_FULL: begin
        if (fire) begin
          s_v_d = 1'b0;
          h_ld  = 1'b1;
          h_din = s_d_q;
        end
      end
      default: begin
        h_v_d = 1'b0;
        s_v_d = 1'b0;
      end
    endcase
    // Flush clears only the valid bits; payload registers keep their contents.
    if (flush) begin
      h_v_d = 1'b0;
      s_v_d = 1'b0;
      h_ld  = 1'b0;
      s_ld  = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (h_v_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      h_v_q   <= 1'b0;
      s_v_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      h_v_q   <= h_v_d;
      s_v_q   <= s_v_d;
      stall_q <= stall_d;
    end
  end

  regn_en #(
    .WIDTH(WIDTH)
  ) u_head (
    .clk(clk),
    .clr(clr),
    .en (h_ld),
    .d  (h_din),
    .q  (h_d_q)
  );

  regn_en #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk(clk),
    .clr(clr),
    .en (s_ld),
    .d  (in_data),
    .q  (s_d_q)
  );

  assign in_ready  = ~s_v_q;
  assign out_valid = h_v_q;
  assign out_data  = h_d_q;
  assign count     = {1'b0, h_v_q} + {1'b0, s_v_q};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Self-checking bench for pipe_skid_latch: queue scoreboard on every cycle,
// a vector table for back-pressure/flush, and directed/random sequences.
module tb_pipe_skid_latch;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       count;
  logic [CNT_W-1:0] stall_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  int         stall_m = 0;
  logic       last_acc;

  pipe_skid_latch #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, advance the queue model across the edge, check outputs.
  task automatic cycle(input logic c, input logic f, input logic iv, input logic [7:0] d,
                       input logic ordy);
    logic m_acc, m_fire, m_stall;
    clr = c; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    m_acc   = iv && (sb.size() < 2);
    m_fire  = (sb.size() > 0) && ordy;
    m_stall = (sb.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    if (c) begin
      sb.delete();
      stall_m = 0;
    end else begin
      if (m_fire) void'(sb.pop_front());
      if (f) sb.delete();
      else if (m_acc) sb.push_back(d);
      if (m_stall && stall_m != SMAX) stall_m++;
    end
    last_acc = m_acc && !c && !f;
    chk("sb_valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("sb_count", 32'(count), 32'(sb.size()));
    chk("sb_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("sb_stall", 32'(stall_cnt), 32'(stall_m));
    if (sb.size() > 0) chk("sb_head", 32'(out_data), 32'(sb[0]));
  endtask

  typedef struct packed {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_valid;
    logic       chk_d;
    logic [7:0] e_data;
    logic [1:0] e_cnt;
    logic       e_ready;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic       cur_v;
    logic [7:0] cur_d;
    logic       fl, ordy;

    // Back-pressure A1..A3, then flush while FULL with 0x55 offered.
    tbl[0] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd2, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'hB1, 2'd0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB1, 2'd0, 1'b1};

    // Reset: two cycles of clr with in_valid high.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
    end

    // Streaming 0x01..0x10 with out_ready high: one word per cycle, count stays 1.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_drain", 32'(out_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].e_ready));
      if (tbl[i].chk_d) chk("tbl_data", 32'(out_data), 32'(tbl[i].e_data));
    end

    // Stall counter saturation, survives flush, cleared by clr.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("sat_start", 32'(stall_cnt), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("sat_cnt", 32'(stall_cnt), 32'((k < 7) ? k : 7));
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("sat_flush", 32'(stall_cnt), 32'd7);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("sat_clr", 32'(stall_cnt), 32'd0);

    // Random valid/ready with ~5% flush; upstream holds its word until accepted.
    cur_v = 1'b0;
    cur_d = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 99) < 70);
        cur_d = 8'($urandom);
      end
      fl   = ($urandom_range(0, 99) < 5);
      ordy = ($urandom_range(0, 99) < 60);
      if (n == 300) cycle(1'b1, 1'b0, cur_v, cur_d, ordy);
      else cycle(1'b0, fl, cur_v, cur_d, ordy);
      if (last_acc) cur_v = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
